// File: rtl/pc_sequencer.sv
// Program counter sequencer: next-PC priority select, irq/undef trap entry with k0 return address.
// Optional trap entry counter enabled by macro PC_SEQUENCER_TRAP_CNT_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h80000000,
  parameter logic [31:0] IRQ_VEC   = 32'h80000004,
  parameter logic [31:0] ILLOP_VEC = 32'h80000008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        irq,
  input  logic        undef,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        kernel,
  output logic        k0_we,
  output logic [31:0] k0_data,
  output logic        irq_ack,
  output logic [15:0] trap_count
);

  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic        run;
  logic        irq_take;
  logic        undef_take;
  logic [31:0] jr_dest;
  logic [31:0] jump_dest;
  logic [31:0] branch_dest;

  assign pc       = pc_q;
  assign kernel   = pc_q[31];
  assign pc_plus4 = {pc_q[31], pc_q[30:0] + 31'd4};

  assign run        = reset & ~stall;
  assign undef_take = run & undef;
  assign irq_take   = run & irq & ~undef & ~kernel;

  // User-mode targets can never set bit 31; kernel mode may clear it to drop privilege.
  assign jr_dest     = {jr_target[31] & kernel, jr_target[30:0] & 31'h7FFFFFFC};
  assign jump_dest   = {pc_q[31] & kernel, pc_q[30:28], jump_index, 2'b00};
  assign branch_dest = {branch_target[31] & kernel, branch_target[30:0]};

  assign k0_we   = (undef_take & ~kernel) | irq_take;
  assign k0_data = undef ? pc_plus4 : pc_q;
  assign irq_ack = irq_take;

  always_comb begin
    pc_next = pc_plus4;
    if (stall)             pc_next = pc_q;
    else if (undef)        pc_next = ILLOP_VEC;
    else if (irq_take)     pc_next = IRQ_VEC;
    else if (jr)           pc_next = jr_dest;
    else if (jump)         pc_next = jump_dest;
    else if (branch_taken) pc_next = branch_dest;
  end

  always_ff @(posedge clk) begin
    if (!reset) pc_q <= RESET_VEC;
    else        pc_q <= pc_next;
  end

`ifdef PC_SEQUENCER_TRAP_CNT_EN
  logic [15:0] trap_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset)
      trap_cnt_q <= 16'd0;
    else if ((undef_take | irq_take) && trap_cnt_q != 16'hFFFF)
      trap_cnt_q <= trap_cnt_q + 16'd1;
  end

  assign trap_count = trap_cnt_q;
`else
  assign trap_count = 16'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized + directed bench for pc_sequencer; per-cycle expectations queued by a reference model.
module tb_pc_sequencer;

  localparam logic [31:0] RST_V = 32'h80000000;
  localparam logic [31:0] IRQ_V = 32'h80000004;
  localparam logic [31:0] ILL_V = 32'h80000008;

  logic        clk = 1'b0;
  logic        reset, stall, irq, undef, branch_taken, jump, jr;
  logic [31:0] branch_target, jr_target;
  logic [25:0] jump_index;
  logic [31:0] pc, pc_plus4, k0_data;
  logic        kernel, k0_we, irq_ack;
  logic [15:0] trap_count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        kernel;
    logic        k0_we;
    logic [31:0] k0_data;
    logic        irq_ack;
    logic [15:0] trap_count;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_pc;
  int unsigned m_tc;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .irq(irq), .undef(undef),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index), .jr(jr), .jr_target(jr_target),
    .pc(pc), .pc_plus4(pc_plus4), .kernel(kernel), .k0_we(k0_we),
    .k0_data(k0_data), .irq_ack(irq_ack), .trap_count(trap_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs sampled mid-cycle, compared against the queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("pc", pc, e.pc);
        check("pc_plus4", pc_plus4, e.pc_plus4);
        check("kernel", {31'd0, kernel}, {31'd0, e.kernel});
        check("k0_we", {31'd0, k0_we}, {31'd0, e.k0_we});
        check("irq_ack", {31'd0, irq_ack}, {31'd0, e.irq_ack});
        check("trap_count", {16'd0, trap_count}, {16'd0, e.trap_count});
        if (e.k0_we) check("k0_data", k0_data, e.k0_data);
      end
    end
  end

  task automatic idle_inputs();
    reset = 1'b1; stall = 1'b0; irq = 1'b0; undef = 1'b0;
    branch_taken = 1'b0; branch_target = 32'd0;
    jump = 1'b0; jump_index = 26'd0; jr = 1'b0; jr_target = 32'd0;
  endtask

  // Reference model: with the current inputs applied, queue this cycle's outputs and advance one edge.
  task automatic step();
    exp_t        e;
    logic [31:0] nxt;
    logic [31:0] user_mask;
    logic [31:0] pc_hi;
    int unsigned tc_next;
    bit          kern;
    kern      = m_pc[31];
    user_mask = kern ? 32'hFFFFFFFF : 32'h7FFFFFFF;
    pc_hi     = m_pc & 32'hF0000000;
    e.pc         = m_pc;
    e.kernel     = kern;
    e.pc_plus4   = (m_pc & 32'h80000000) | ((m_pc + 32'd4) & 32'h7FFFFFFF);
    e.k0_we      = 1'b0;
    e.k0_data    = 32'd0;
    e.irq_ack    = 1'b0;
    e.trap_count = m_tc[15:0];
    tc_next      = m_tc;
    if (!reset) begin
      nxt = RST_V;
      tc_next = 0;
    end else if (stall) begin
      nxt = m_pc;
    end else if (undef) begin
      nxt = ILL_V;
      if (!kern) begin
        e.k0_we = 1'b1;
        e.k0_data = e.pc_plus4;
      end
      tc_next = (m_tc < 65535) ? m_tc + 1 : m_tc;
    end else if (irq && !kern) begin
      nxt = IRQ_V;
      e.k0_we = 1'b1;
      e.k0_data = m_pc;
      e.irq_ack = 1'b1;
      tc_next = (m_tc < 65535) ? m_tc + 1 : m_tc;
    end else if (jr) begin
      nxt = (jr_target & 32'hFFFFFFFC) & user_mask;
    end else if (jump) begin
      nxt = (pc_hi | (32'(jump_index) * 4)) & user_mask;
    end else if (branch_taken) begin
      nxt = branch_target & user_mask;
    end else begin
      nxt = e.pc_plus4;
    end
`ifndef PC_SEQUENCER_TRAP_CNT_EN
    e.trap_count = 16'd0;
    tc_next = 0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    m_pc = nxt;
    m_tc = tc_next;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    @(posedge clk);
    #1;
    m_pc = RST_V;
    m_tc = 0;

    // reset held with trap inputs active: no strobes, pc stays at reset vector
    reset = 1'b0; irq = 1'b1; undef = 1'b1; stall = 1'b1; step();
    idle_inputs();

    repeat (3) step();
    check("boot_pc", m_pc, 32'h8000000C);

    jr = 1'b1; jr_target = 32'h00000010; step(); idle_inputs();
    check("jr_to_user", m_pc, 32'h00000010);
    jump = 1'b1; jump_index = 26'h3; step(); idle_inputs();
    check("jump_idx3", m_pc, 32'h0000000C);

    jump = 1'b1; jump_index = 26'h10; step(); idle_inputs();
    irq = 1'b1; step();
    check("irq_vec", m_pc, IRQ_V);
    repeat (2) step();
    jr = 1'b1; jr_target = 32'h00000020; step(); jr = 1'b0;
    step();
    check("irq_after_jr", m_pc, IRQ_V);
    idle_inputs();

    jr = 1'b1; jr_target = 32'h00000020; step(); idle_inputs();
    undef = 1'b1; irq = 1'b1; step(); idle_inputs();
    check("undef_vec", m_pc, ILL_V);

    jr = 1'b1; jr_target = 32'h00000103; step(); idle_inputs();
    check("jr_align", m_pc, 32'h00000100);
    stall = 1'b1; irq = 1'b1; jump = 1'b1; jump_index = 26'h55; step();
    stall = 1'b0; jump = 1'b0; step(); idle_inputs();

    jr = 1'b1; jr_target = 32'h00000040; step(); idle_inputs();
    branch_taken = 1'b1; branch_target = 32'h80001234; step(); idle_inputs();
    jr = 1'b1; jr_target = 32'h80000000; step(); idle_inputs();
    check("jr_no_priv", m_pc, 32'h00000000);
    step();
    reset = 1'b0; undef = 1'b1; step(); idle_inputs();
    check("mid_reset", m_pc, RST_V);

    // kernel-mode undef: vector taken without k0 write
    undef = 1'b1; step(); idle_inputs();

    for (int i = 0; i < 600; i++) begin
      reset         = ($urandom_range(99) >= 2);
      stall         = ($urandom_range(99) < 15);
      irq           = ($urandom_range(99) < 30);
      undef         = ($urandom_range(99) < 5);
      jr            = ($urandom_range(99) < 12);
      jump          = ($urandom_range(99) < 12);
      branch_taken  = ($urandom_range(99) < 20);
      jr_target     = $urandom;
      branch_target = $urandom;
      jump_index    = 26'($urandom);
      if ($urandom_range(99) < 50) jr_target[31] = 1'b0;
      if (i % 50 == 7) jr_target = 32'h7FFFFFFC;
      step();
    end
    idle_inputs();
    step();

    @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h80000000, meaning the PC loaded at reset (kernel mode).
REQ-002 SHALL have parameter IRQ_VEC, default 32'h80000004, meaning the interrupt handler entry.
REQ-003 SHALL have parameter ILLOP_VEC, default 32'h80000008, meaning the undefined-instruction handler entry.
REQ-004 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port: reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have port: stall  in  1  hold the PC this cycle.
REQ-007 SHALL have port: irq  in  1  level interrupt request from the timer peripheral.
REQ-008 SHALL have port: undef  in  1  decoder flags the current instruction as undefined.
REQ-009 SHALL have port: branch_taken  in  1  conditional branch resolves taken.
REQ-010 SHALL have port: branch_target  in  32  branch destination.
REQ-011 SHALL have port: jump  in  1  j/jal decoded.
REQ-012 SHALL have port: jump_index  in  26  instruction field [25:0].
REQ-013 SHALL have port: jr  in  1  jr/jalr decoded.
REQ-014 SHALL have port: jr_target  in  32  rs register value.
REQ-015 SHALL have port: pc  out  32  instruction fetch address to instruction memory.
REQ-016 SHALL have port: pc_plus4  out  32  pc+4, with bit 31 equal to pc[31].
REQ-017 SHALL have port: kernel  out  1  equals pc[31].
REQ-018 SHALL have port: k0_we  out  1  write strobe for register $26.
REQ-019 SHALL have port: k0_data  out  32  return address for $26.
REQ-020 SHALL have port: irq_ack  out  1  one-cycle pulse when an interrupt is accepted.
REQ-021 SHALL have port: trap_count  out  16  trap entry counter (see Configuration).

Function
REQ-022 SHALL hold the PC in one 32-bit register; pc SHALL be that register directly, with no combinational path from inputs.
REQ-023 SHALL select next PC, when stall=0, by priority: undef > accepted irq > jr > jump > branch_taken > pc_plus4.
REQ-024 SHALL accept an irq only when irq=1, kernel=0, stall=0 and undef=0.
REQ-025 SHALL treat irq as level-sensitive: an irq raised in kernel mode waits; it is accepted in the first user-mode cycle in which REQ-024 holds.
REQ-026 On undef=1 in user mode: next PC=ILLOP_VEC, k0_we=1, k0_data=pc_plus4.
REQ-027 On undef=1 in kernel mode: next PC=ILLOP_VEC, k0_we=0.
REQ-028 On irq accept: next PC=IRQ_VEC, k0_we=1, k0_data=pc (the interrupted instruction is re-executed), irq_ack=1.
REQ-029 k0_we, k0_data and irq_ack SHALL be combinational in the trap cycle, so the register file captures k0 on the same edge as the PC update.
REQ-030 Jump target SHALL be {pc[31:28], jump_index, 2'b00}.
REQ-031 jr SHALL load jr_target; bit 31 may go 1->0, leaving kernel mode, but SHALL NOT go 0->1.
REQ-032 In user mode, bit 31 of every jump and branch target SHALL be forced to 0.
REQ-033 jr_target[1:0] SHALL be forced to 0.
REQ-034 stall=1 SHALL hold pc and force k0_we=0 and irq_ack=0; all other inputs are ignored that cycle.
REQ-035 PC arithmetic SHALL wrap modulo 2^31 in bits [30:0]; pc_plus4 SHALL never change bit 31.

Reset
REQ-036 When reset=0 at a clock edge: pc=RESET_VEC and trap_count=0, regardless of stall or other inputs.
REQ-037 While reset=0: k0_we=0 and irq_ack=0.
REQ-038 Reset asserted mid-trap SHALL discard the trap; no pending state survives reset.

Configuration
REQ-039 With macro PC_SEQUENCER_TRAP_CNT_EN defined: trap_count increments by 1 on every accepted irq or undef trap, and saturates at 16'hFFFF.
REQ-040 Without PC_SEQUENCER_TRAP_CNT_EN: trap_count is constant 0 and no counter flops exist.

Verification
REQ-041 Release reset, drive no control inputs for 3 cycles -> pc reads 80000000, 80000004, 80000008; kernel=1.
REQ-042 In kernel, jr=1 with jr_target=32'h00000010 -> next pc=00000010, kernel=0; then jump_index=26'h3 -> pc=0000000C.
REQ-043 User pc=00000040, irq=1 -> irq_ack=1, k0_we=1, k0_data=00000040; next pc=80000004. irq kept high in kernel -> no second ack until jr drops to user.
REQ-044 User pc=00000020 with undef=1 and irq=1 together -> next pc=80000008, k0_data=00000024, irq_ack=0; trap_count +1 when macro defined.
REQ-045 stall=1 with irq=1 and jump=1 -> pc unchanged, k0_we=0, irq_ack=0; releasing the stall -> irq accepted.
REQ-046 User mode, jr_target=32'h80000000 -> pc=00000000, kernel stays 0; reset=0 mid-sequence -> pc=80000000 next edge.
